relu_layer_ctrl: RTL and testbench

RELU_LAYER_CTRL -- requirements
Module: relu_layer_ctrl

---
 rtl/relu_pkg.sv | 14 +
 rtl/relu_share_unit.sv | 21 ++
 rtl/relu_layer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_relu_layer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pkg.sv
// Shared types and constants for the ReLU layer controller and its share arithmetic.
package relu_pkg;

  localparam int unsigned PIPE_DEPTH = 2;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/relu_share_unit.sv
// Combinational share arithmetic: the masked sum r1+e and the ReLU re-masking with r2.
module relu_share_unit #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] r1_i,
  input  logic [N-1:0] e_i,
  output logic         c_o,
  output logic [N-1:0] x_o,
  input  logic         c_i,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] r2_i,
  output logic [N-1:0] res_o
);

  // The carry of r1+e marks a positive element; the final add wraps mod 2^N.
  always_comb begin
    {c_o, x_o} = (N+1)'(r1_i) + (N+1)'(e_i);
    res_o      = (c_i ? x_i : '0) + r2_i;
  end

endmodule

// File: rtl/relu_layer_ctrl.sv
// Job controller and two-stage pipeline for a shared-secret ReLU layer.
// Optional positive-element counter enabled by defining RELU_POS_COUNT_EN.
module relu_layer_ctrl
  import relu_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned LEN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_g,
  input  logic [N-1:0]   in_e,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_last,
  output logic [15:0]    pos_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_c_q, s1_c_d;
  logic [N-1:0]     s1_x_q, s1_x_d;
  logic [N-1:0]     s1_r2_q, s1_r2_d;
  logic             s1_last_q, s1_last_d;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             s2_adv_c, s1_adv_c, in_hs_c, out_hs_c, is_last_c;
  logic             sum_c_c;
  logic [N-1:0]     sum_x_c, res_c;

  relu_share_unit #(.N(N)) u_share (
    .r1_i  (in_g[2*N-1:N]),
    .e_i   (in_e),
    .c_o   (sum_c_c),
    .x_o   (sum_x_c),
    .c_i   (s1_c_q),
    .x_i   (s1_x_q),
    .r2_i  (s1_r2_q),
    .res_o (res_c)
  );

  // Handshakes and pipeline advance conditions
  always_comb begin
    s2_adv_c  = !out_valid_q || out_ready;
    s1_adv_c  = !s1_valid_q || s2_adv_c;
    in_ready  = (state_q == RUN) && s1_adv_c;
    in_hs_c   = in_valid && in_ready;
    out_hs_c  = out_valid_q && out_ready;
    is_last_c = (cnt_q == CNT_W'(LEN - 1));
  end

  // Next state, element counter and pipeline stage loads
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_c_d      = s1_c_q;
    s1_x_d      = s1_x_q;
    s1_r2_d     = s1_r2_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (in_hs_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_last_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs_c && out_last_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (s1_adv_c) begin
      s1_valid_d = in_hs_c;
      if (in_hs_c) begin
        s1_c_d    = sum_c_c;
        s1_x_d    = sum_x_c;
        s1_r2_d   = in_g[N-1:0];
        s1_last_d = is_last_c;
      end
    end

    // Output register only reloads on a real element so stalled data stays put
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_c;
        out_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_c_q      <= 1'b0;
      s1_x_q      <= '0;
      s1_r2_q     <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_c_q      <= s1_c_d;
      s1_x_q      <= s1_x_d;
      s1_r2_q     <= s1_r2_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef RELU_POS_COUNT_EN
  logic [15:0] pos_q, pos_d;

  // Counts positive elements as they enter stage 1, saturating at all-ones
  always_comb begin
    pos_d = pos_q;
    if ((state_q == IDLE) && start) begin
      pos_d = '0;
    end else if (in_hs_c && sum_c_c && (pos_q != 16'hFFFF)) begin
      pos_d = pos_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  assign pos_count = pos_q;
`else
  assign pos_count = '0;
`endif

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Directed-plus-random bench for relu_layer_ctrl (N=8, LEN=4) against a queue-based reference.
module tb_relu_layer_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned LEN = 4;

  typedef struct {
    logic [N-1:0] data;
    logic         last;
    int           cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, busy, done;
  logic           in_valid, in_ready, out_valid, out_ready, out_last;
  logic [2*N-1:0] in_g;
  logic [N-1:0]   in_e, out_data;
  logic [15:0]    pos_count;

  relu_layer_ctrl #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_g      (in_g),
    .in_e      (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pos_count (pos_count)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [N-1:0] vr1 [LEN];
  logic [N-1:0] ve  [LEN];
  logic [N-1:0] vr2 [LEN];
  exp_t         exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: true value x = r1 + e wraps past 2^N exactly when x is positive
  function automatic logic [N-1:0] ref_out(input int r1, input int e, input int r2);
    int s;
    s = r1 + e;
    if (s >= (1 << N)) return N'((s - (1 << N) + r2) % (1 << N));
    return N'(r2);
  endfunction

  function automatic int ref_pos(input int r1, input int e);
    return ((r1 + e) >= (1 << N)) ? 1 : 0;
  endfunction

  function automatic int exp_pos(input int p);
`ifdef RELU_POS_COUNT_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  task automatic rand_vectors();
    for (int i = 0; i < int'(LEN); i++) begin
      vr1[i] = N'($urandom_range(0, 255));
      ve[i]  = N'($urandom_range(0, 255));
      vr2[i] = N'($urandom_range(0, 255));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_pos"},       32'(pos_count), 32'd0);
  endtask

  // mode 0: no backpressure, 1: out_ready low 3 cycles, 2: reset after 2 inputs, 3: start while busy
  task automatic run_job(input int mode);
    int           sent, got, done_exp, pos_exp, t, idx;
    bit           prev_stall, nostall, exp_ov;
    logic [N-1:0] prev_data;
    logic         prev_last;
    sent = 0; got = 0; pos_exp = 0; t = 0;
    done_exp   = 1 << 30;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    nostall    = (mode != 1);
    exp_q.delete();

    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;

    while (cyc <= done_exp && t < 100) begin
      if (mode == 2 && sent == 2) begin
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("midrst_no_done", 32'(done), 32'd0);
          chk("midrst_idle_busy", 32'(busy), 32'd0);
        end
        return;
      end

      idx       = (sent < int'(LEN)) ? sent : 0;
      start     = (mode == 3 && (t == 2 || t == 4));
      in_valid  = (sent < int'(LEN));
      in_g      = {vr1[idx], vr2[idx]};
      in_e      = ve[idx];
      out_ready = !(mode == 1 && t >= 2 && t < 5);
      #1;

      if (t == 0) chk("pos_cleared", 32'(pos_count), 32'd0);
      chk("done", 32'(done), 32'(cyc == done_exp));
      chk("busy", 32'(busy), 32'(cyc < done_exp));
      if (sent == int'(LEN)) chk("in_ready_after_len", 32'(in_ready), 32'd0);
      if (nostall) begin
        exp_ov = (exp_q.size() > 0) && (exp_q[0].cyc + 2 == cyc);
        chk("latency_out_valid", 32'(out_valid), 32'(exp_ov));
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  32'(out_data),  32'(prev_data));
        chk("stall_last",  32'(out_last),  32'(prev_last));
      end

      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].data));
          chk("out_last", 32'(out_last), 32'(exp_q[0].last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
            if (got == int'(LEN)) done_exp = cyc + 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;

      if (in_valid && in_ready) begin
        exp_q.push_back('{ref_out(int'(vr1[idx]), int'(ve[idx]), int'(vr2[idx])),
                          (sent == int'(LEN) - 1), cyc});
        pos_exp += ref_pos(int'(vr1[idx]), int'(ve[idx]));
        sent++;
      end

      tick();
      t++;
    end

    start = 1'b0; in_valid = 1'b0;
    if (t >= 100) chk("job_timeout_outputs", 32'(got), 32'(LEN));
    #1;
    chk("end_busy",      32'(busy),      32'd0);
    chk("end_done",      32'(done),      32'd0);
    chk("end_in_ready",  32'(in_ready),  32'd0);
    chk("end_out_valid", 32'(out_valid), 32'd0);
    chk("end_pos_count", 32'(pos_count), 32'(exp_pos(pos_exp)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_g = '0; in_e = '0;
    tick();
    tick();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Directed: negative element, positive element, zero-crossing cases
    vr1[0] = 8'h10; ve[0] = 8'h05; vr2[0] = 8'h03;
    vr1[1] = 8'hF0; ve[1] = 8'h20; vr2[1] = 8'h01;
    vr1[2] = 8'h7F; ve[2] = 8'h81; vr2[2] = 8'hAA;
    vr1[3] = 8'hFF; ve[3] = 8'h00; vr2[3] = 8'h55;
    chk("model_neg", 32'(ref_out(int'(vr1[0]), int'(ve[0]), int'(vr2[0]))), 32'h03);
    chk("model_pos", 32'(ref_out(int'(vr1[1]), int'(ve[1]), int'(vr2[1]))), 32'h11);
    run_job(0);

    // Single positive element job counter view
    vr1[0] = 8'hF0; ve[0] = 8'h20; vr2[0] = 8'h01;
    vr1[1] = 8'h10; ve[1] = 8'h05; vr2[1] = 8'h03;
    vr1[2] = 8'h01; ve[2] = 8'h01; vr2[2] = 8'h00;
    vr1[3] = 8'h00; ve[3] = 8'h00; vr2[3] = 8'hFF;
    run_job(0);

    for (int j = 0; j < 3; j++) begin
      rand_vectors();
      run_job(0);
    end
    for (int j = 0; j < 3; j++) begin
      rand_vectors();
      run_job(1);
    end
    rand_vectors();
    run_job(2);
    rand_vectors();
    run_job(0);
    rand_vectors();
    run_job(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
